pll_freq_acq_sequencer: RTL
===========================

// Module: pll_freq_acq_sequencer
// PURPOSE
//  Frequency-acquisition sequencer for the DCO thermometer code in the all-digital PLL, running in the reference-clock domain.
//  Per decision, takes synchronized too-slow/too-fast flags and moves a level register (number of enabled DCO cells).
//  Search runs coarse (step halves on each direction flip), then fine, then locked tracking with unlock detection.
//  Drives the DCO EN bus and freq_lock to the rest of the PLL.
// PARAMETERS
//  N_BITS      132  DCO enable cells (dco_code width); LW = $clog2(N_BITS+1) = 8
//  INIT_LEVEL  3    level held in reset and IDLE (dco_code = 'h7)
//  STEP_INIT   32   first coarse step; power of two
//  UNLOCK_STEP 8    coarse step reloaded after loss of lock; power of two
//  SETTLE_CYC  2    cycles after each level change during which decisions are ignored
//  LOCK_CNT    8    consecutive direction alternations in FINE needed to declare lock
//  UNLOCK_RUN  4    consecutive same-direction decisions in LOCKED that drop lock
// PORTS
//  ref_clk   in  1       reference clock; all state on posedge
//  reset_    in  1       asynchronous, active-low reset
//  en        in  1       1 = run acquisition; 0 = return to IDLE
//  up        in  1       DCO too slow this ref period (synchronized, one flag per cycle)
//  dn        in  1       DCO too fast this ref period (synchronized)
//  dco_code  out N_BITS  thermometer code: bits [level-1:0] = 1, all others 0
//  level     out LW      current level, 0..N_BITS
//  state     out 2       IDLE=0, COARSE=1, FINE=2, LOCKED=3
//  freq_lock out 1       registered lock flag
// BEHAVIOUR
//  Reset (async, reset_=0): level=INIT_LEVEL, dco_code='h7, state=IDLE, freq_lock=0, step=STEP_INIT, settle=0, last_dir valid=0, alt_cnt=run_cnt=0.
//  dco_code is a combinational decode of the level register, so it changes in the same cycle as level.
//  Decision: cycle with settle==0, state!=IDLE, and up^dn==1. up=1: dir=+1; dn=1: dir=-1.
//  up&dn both 1, or both 0: no decision; nothing changes.
//  Accepted decision: level updates on that edge; settle loads SETTLE_CYC and decrements to 0; last_dir is recorded.
//  Arithmetic is done LW+1 bits wide and saturates: level+step is clipped to N_BITS, level-step is clipped to 0.
//  A saturated decision still counts as a decision (dir recorded, counters updated).
//  IDLE: level held at INIT_LEVEL. en=1 -> COARSE with step=STEP_INIT and last_dir invalid.
//  COARSE: if last_dir is valid and dir!=last_dir, step=step>>1 and the new step is applied on this decision.
//    When the applied step equals 1 -> FINE with alt_cnt=0.
//  FINE: step 1. dir!=last_dir -> alt_cnt++; otherwise alt_cnt=0.
//    alt_cnt reaching LOCK_CNT -> LOCKED; freq_lock=1 from the same edge; run_cnt=0.
//  LOCKED: step 1. dir==last_dir -> run_cnt++; otherwise run_cnt=1.
//    run_cnt reaching UNLOCK_RUN -> COARSE with step=UNLOCK_STEP, freq_lock=0, last_dir invalid.
//  en=0 in any state: next edge -> IDLE, level=INIT_LEVEL, freq_lock=0, all counters cleared.
//  en takes priority over a decision in the same cycle.
//  Reset mid-operation: immediate return to the reset values. No partial update survives.
// STRUCTURE
//  pll_ctrl_pkg: state encoding, LW function, default parameter constants. Shared with the other PLL control blocks.
//  Sub-module therm_decoder #(N_BITS): level -> dco_code (combinational).
//  Top level holds the FSM, the settle counter, the step register and the alt/run counters.
// TESTING
//  1 Reset: reset_=0 -> dco_code='h7, level=3, state=0, freq_lock=0. Release with en=0 -> state stays IDLE.
//  2 Climb: en=1, up held -> level 35, 67, 99, 131, 132 (saturated), one change every 3 cycles; nothing changes during settle.
//  3 Halving: up to 67, then dn -> 51 (step16), up -> 59 (8), dn -> 55 (4), up -> 57 (2), dn -> 56 (1) -> state FINE.
//  4 Lock: in FINE, 8 alternating up/dn decisions -> state LOCKED, freq_lock=1 on the 8th decision edge.
//  5 Unlock: in LOCKED, 4 consecutive dn -> freq_lock=0, state COARSE; next up moves level +8.
//  6 Edges: up=dn=1 -> no change; level 0 with dn -> stays 0; en=0 mid-FINE -> IDLE, level 3 next cycle; async reset_ pulse mid-COARSE -> reset values.

Source files
------------

// File: rtl/pll_freq_acq_sequencer_pkg.sv
// Shared PLL control definitions: acquisition state encoding, default constants, level-width helper.
// Latency: n/a (types and constants only); backpressure: n/a.
package pll_freq_acq_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COARSE = 2'd1,
        ST_FINE   = 2'd2,
        ST_LOCKED = 2'd3
    } acq_state_t;

    localparam int N_BITS_DEF      = 132;
    localparam int INIT_LEVEL_DEF  = 3;
    localparam int STEP_INIT_DEF   = 32;
    localparam int UNLOCK_STEP_DEF = 8;
    localparam int SETTLE_CYC_DEF  = 2;
    localparam int LOCK_CNT_DEF    = 8;
    localparam int UNLOCK_RUN_DEF  = 4;

    // Width needed to hold a level in 0..n inclusive.
    function automatic int lw_of(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pll_freq_acq_sequencer_if.sv
// Decision inputs and DCO control outputs of the frequency-acquisition sequencer.
// Latency: n/a (wires only); backpressure: none, one decision flag pair per reference cycle.
interface pll_freq_acq_sequencer_if
    import pll_freq_acq_sequencer_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
);
    localparam int LW = lw_of(N_BITS);

    logic              en;
    logic              up;
    logic              dn;
    logic [N_BITS-1:0] dco_code;
    logic [LW-1:0]     level;
    acq_state_t        state;
    logic              freq_lock;

    modport master (
        output en, up, dn,
        input  dco_code, level, state, freq_lock
    );

    modport slave (
        input  en, up, dn,
        output dco_code, level, state, freq_lock
    );
endinterface

// File: rtl/pll_freq_acq_sequencer_therm_decoder.sv
// Level to DCO thermometer code: bits below level are set.
// Latency: combinational; backpressure: none.
module therm_decoder #(
    parameter int N_BITS = 132,
    parameter int LW     = $clog2(N_BITS + 1)
) (
    input  logic [LW-1:0]     level_i,
    output logic [N_BITS-1:0] code_o
);

    always_comb begin
        code_o = '0;
        for (int i = 0; i < N_BITS; i++) begin
            code_o[i] = (LW'(i) < level_i);
        end
    end

endmodule

// File: rtl/pll_freq_acq_sequencer.sv
// DCO frequency acquisition: coarse binary search, fine step, locked tracking with unlock detection.
// Latency: level/state/lock update on the decision edge; backpressure: none, decisions inside the settle window are dropped.
module pll_freq_acq_sequencer
    import pll_freq_acq_sequencer_pkg::*;
#(
    parameter int N_BITS      = N_BITS_DEF,
    parameter int INIT_LEVEL  = INIT_LEVEL_DEF,
    parameter int STEP_INIT   = STEP_INIT_DEF,
    parameter int UNLOCK_STEP = UNLOCK_STEP_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int LOCK_CNT    = LOCK_CNT_DEF,
    parameter int UNLOCK_RUN  = UNLOCK_RUN_DEF
) (
    input  logic                      ref_clk,
    input  logic                      reset_,
    pll_freq_acq_sequencer_if.slave   bus
);

    localparam int LW = lw_of(N_BITS);
    localparam int SW = $clog2(SETTLE_CYC + 2);
    localparam int AW = $clog2(LOCK_CNT + 1);
    localparam int RW = $clog2(UNLOCK_RUN + 1);

    acq_state_t    state_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] step_q;
    logic [SW-1:0] settle_q;
    logic          last_dir_q;
    logic          last_vld_q;
    logic [AW-1:0] alt_cnt_q;
    logic [RW-1:0] run_cnt_q;
    logic          freq_lock_q;

    logic          decide;
    logic          dir_up;
    logic          flip;
    logic [LW-1:0] step_d;
    logic [LW:0]   sum_w;
    logic [LW:0]   diff_w;
    logic [LW-1:0] level_d;
    logic [AW-1:0] alt_cnt_d;
    logic [RW-1:0] run_cnt_d;

    always_comb begin
        decide    = (settle_q == '0) && (state_q != ST_IDLE) && (bus.up ^ bus.dn);
        dir_up    = bus.up;
        flip      = last_vld_q && (dir_up != last_dir_q);
        // Only coarse search uses the step register; fine and locked always move by one.
        step_d    = (state_q == ST_COARSE) ? (flip ? (step_q >> 1) : step_q) : LW'(1);
        sum_w     = {1'b0, level_q} + {1'b0, step_d};
        diff_w    = {1'b0, level_q} - {1'b0, step_d};
        level_d   = level_q;
        if (dir_up) begin
            level_d = (sum_w > (LW+1)'(N_BITS)) ? LW'(N_BITS) : sum_w[LW-1:0];
        end else begin
            level_d = diff_w[LW] ? '0 : diff_w[LW-1:0];
        end
        alt_cnt_d = flip ? alt_cnt_q + AW'(1) : '0;
        run_cnt_d = flip ? RW'(1) : run_cnt_q + RW'(1);
    end

    always_ff @(posedge ref_clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= ST_IDLE;
            level_q     <= LW'(INIT_LEVEL);
            step_q      <= LW'(STEP_INIT);
            settle_q    <= '0;
            last_dir_q  <= 1'b0;
            last_vld_q  <= 1'b0;
            alt_cnt_q   <= '0;
            run_cnt_q   <= '0;
            freq_lock_q <= 1'b0;
        end else if (!bus.en) begin
            state_q     <= ST_IDLE;
            level_q     <= LW'(INIT_LEVEL);
            step_q      <= LW'(STEP_INIT);
            settle_q    <= '0;
            last_dir_q  <= 1'b0;
            last_vld_q  <= 1'b0;
            alt_cnt_q   <= '0;
            run_cnt_q   <= '0;
            freq_lock_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            state_q    <= ST_COARSE;
            step_q     <= LW'(STEP_INIT);
            last_vld_q <= 1'b0;
        end else begin
            if (settle_q != '0) begin
                settle_q <= settle_q - SW'(1);
            end
            if (decide) begin
                level_q    <= level_d;
                settle_q   <= SW'(SETTLE_CYC);
                last_dir_q <= dir_up;
                last_vld_q <= 1'b1;
                case (state_q)
                    ST_COARSE: begin
                        step_q <= step_d;
                        if (step_d == LW'(1)) begin
                            state_q   <= ST_FINE;
                            alt_cnt_q <= '0;
                        end
                    end
                    ST_FINE: begin
                        alt_cnt_q <= alt_cnt_d;
                        if (alt_cnt_d == AW'(LOCK_CNT)) begin
                            state_q     <= ST_LOCKED;
                            freq_lock_q <= 1'b1;
                            run_cnt_q   <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        run_cnt_q <= run_cnt_d;
                        // A sustained one-sided drift means the loop has lost the target.
                        if (run_cnt_d == RW'(UNLOCK_RUN)) begin
                            state_q     <= ST_COARSE;
                            step_q      <= LW'(UNLOCK_STEP);
                            freq_lock_q <= 1'b0;
                            last_vld_q  <= 1'b0;
                            run_cnt_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    therm_decoder #(
        .N_BITS (N_BITS),
        .LW     (LW)
    ) u_therm_decoder (
        .level_i (level_q),
        .code_o  (bus.dco_code)
    );

    assign bus.level     = level_q;
    assign bus.state     = state_q;
    assign bus.freq_lock = freq_lock_q;

endmodule
